// File: rtl/fcw_nco.sv
// fcw_nco: numerically controlled oscillator for the piano synth.
// Accumulates the frequency control word into a phase register on every
// sample strobe, looks the phase up in a quarter-wave sine ROM and presents
// an offset-binary sample to the PWM DAC two cycles after the strobe.
module fcw_nco #(
  parameter int FCW_WIDTH  = 24,
  parameter int CODE_WIDTH = 10,
  parameter int QTR_ADDR   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FCW_WIDTH-1:0]  fcw,
  input  logic                  next_sample_fetch,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid
);

  localparam int MAG_W     = CODE_WIDTH - 1;
  localparam int ROM_DEPTH = 1 << QTR_ADDR;
  localparam int TOP_W     = QTR_ADDR + 2;
  localparam logic [CODE_WIDTH-1:0] MIDSCALE = {1'b1, {(CODE_WIDTH-1){1'b0}}};

  // Quarter-wave entry i samples the sine at the centre of its bin, so the
  // table never holds 0 and the mirrored quadrants join without a duplicate.
  function automatic logic [MAG_W-1:0] romEntry(input int i);
    real angle;
    real amp;
    angle = (3.14159265358979323846 / 2.0) * (real'(i) + 0.5) / real'(ROM_DEPTH);
    amp   = real'((1 << MAG_W) - 1) * $sin(angle);
    return MAG_W'($rtoi(amp + 0.5));
  endfunction

  logic [MAG_W-1:0] romTable [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : gRom
    localparam logic [MAG_W-1:0] ENTRY = romEntry(g);
    assign romTable[g] = ENTRY;
  end

  logic [FCW_WIDTH-1:0]  phase_q, phase_d;
  logic [TOP_W-1:0]      topBits;
  logic [1:0]            quadrant;
  logic [QTR_ADDR-1:0]   romIdx;
  logic [QTR_ADDR-1:0]   romAddr;
  logic [MAG_W-1:0]      mag_d;
  logic [MAG_W-1:0]      mag_q;
  logic                  negHalf_q;
  logic                  silent_q;
  logic                  sampleValid_q;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  codeValid_q;

  // Next phase and ROM lookup; the sample is built from the updated phase,
  // and a zero word parks the phase at 0 so the next note starts cleanly.
  always_comb begin
    phase_d = phase_q + fcw;
    if (fcw == '0) begin
      phase_d = '0;
    end
    topBits  = phase_d[FCW_WIDTH-1 -: TOP_W];
    quadrant = topBits[QTR_ADDR+1:QTR_ADDR];
    romIdx   = topBits[QTR_ADDR-1:0];
    romAddr  = quadrant[0] ? ~romIdx : romIdx;
    mag_d    = romTable[romAddr];
  end

  // Phase accumulator and first pipeline stage, advanced only on a strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q       <= '0;
      mag_q         <= '0;
      negHalf_q     <= 1'b0;
      silent_q      <= 1'b0;
      sampleValid_q <= 1'b0;
    end else begin
      sampleValid_q <= next_sample_fetch;
      if (next_sample_fetch) begin
        phase_q   <= phase_d;
        mag_q     <= mag_d;
        negHalf_q <= quadrant[1];
        silent_q  <= (fcw == '0);
      end
    end
  end

  // Offset-binary reconstruction: the lower half-cycle subtracts from midscale.
  always_comb begin
    code_d = MIDSCALE + {1'b0, mag_q};
    if (silent_q) begin
      code_d = MIDSCALE;
    end else if (negHalf_q) begin
      code_d = MIDSCALE - {1'b0, mag_q};
    end
  end

  // Output register: code only changes when a sample lands, so it holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q      <= MIDSCALE;
      codeValid_q <= 1'b0;
    end else begin
      codeValid_q <= sampleValid_q;
      if (sampleValid_q) begin
        code_q <= code_d;
      end
    end
  end

  assign code       = code_q;
  assign code_valid = codeValid_q;

endmodule
